scan_sequencer: RTL and testbench

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_sequencer.sv | 115 +++++++++++
 tb/tb_scan_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// Scan sequencer: steps a 4-bit decoder select code up or down once every TICK_DIV
// cycles, from its loaded value until it reaches a latched terminal code.
module scan_sequencer #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dir,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic [3:0] stop_val,
    input  logic       halt,
    output logic       e,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       active,
    output logic       done
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;
    logic [3:0]    w_step;
    logic [PW-1:0] r_pre;
    logic [PW-1:0] w_pre_nxt;
    logic          r_dir_q;
    logic          w_dir_nxt;
    logic [3:0]    r_stop_q;
    logic [3:0]    w_stop_nxt;

    // The 4-bit arithmetic gives the modulo-16 wrap in both directions.
    assign w_step = r_dir_q ? (r_cnt - 4'd1) : (r_cnt + 4'd1);

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_pre    <= {PW{1'b0}};
            r_dir_q  <= 1'b0;
            r_stop_q <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_pre    <= w_pre_nxt;
            r_dir_q  <= w_dir_nxt;
            r_stop_q <= w_stop_nxt;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pre_nxt   = r_pre;
        w_dir_nxt   = r_dir_q;
        w_stop_nxt  = r_stop_q;
        case (r_state)
            IDLE: begin
                if (load) begin
                    w_cnt_nxt = load_val;
                end else if (start) begin
                    w_state_nxt = RUN;
                    w_pre_nxt   = {PW{1'b0}};
                    w_dir_nxt   = dir;
                    w_stop_nxt  = stop_val;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                // Halt wins over a coincident tick so an abort never moves the code.
                if (halt) begin
                    w_state_nxt = IDLE;
                    w_pre_nxt   = {PW{1'b0}};
                end else if (r_pre == PRE_TOP) begin
                    w_pre_nxt = {PW{1'b0}};
                    w_cnt_nxt = w_step;
                    if (w_step == r_stop_q) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end else begin
                    w_pre_nxt = r_pre + PW'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign e      = r_cnt[3];
    assign x      = r_cnt[2];
    assign y      = r_cnt[1];
    assign z      = r_cnt[0];
    assign active = (r_state == RUN);
    assign done   = (r_state == DONE);

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: a table of runs on a TICK_DIV=4 instance plus hand-written
// halt, load/start, reset and TICK_DIV=1 sequences, using a queue of expected codes.
module tb_scan_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       start4, dir4, load4, halt4;
    logic [3:0] lv4, sv4;
    logic       start1, dir1, load1, halt1;
    logic [3:0] lv1, sv1;
    logic       e4, x4, y4, z4, act4, done4;
    logic       e1, x1, y1, z1, act1, done1;

    int total = 0;
    int bad   = 0;
    int cur[2];
    int q[$];

    typedef struct {
        int lv;
        int dir;
        int stop;
        int steps;
        int fin;
    } vec_t;
    vec_t tbl[6];

    scan_sequencer #(.TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .dir(dir4), .load(load4),
        .load_val(lv4), .stop_val(sv4), .halt(halt4),
        .e(e4), .x(x4), .y(y4), .z(z4), .active(act4), .done(done4)
    );

    scan_sequencer #(.TICK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .dir(dir1), .load(load1),
        .load_val(lv1), .stop_val(sv1), .halt(halt1),
        .e(e1), .x(x1), .y(y1), .z(z1), .active(act1), .done(done1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int a, input int xp);
        total++;
        if (a !== xp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, a, xp);
        end
    endtask

    function automatic int code_of(input int s);
        return (s != 0) ? int'({e1, x1, y1, z1}) : int'({e4, x4, y4, z4});
    endfunction

    function automatic int act_of(input int s);
        return (s != 0) ? int'(act1) : int'(act4);
    endfunction

    function automatic int done_of(input int s);
        return (s != 0) ? int'(done1) : int'(done4);
    endfunction

    task automatic set_in(input int s, input logic st, input logic d, input logic ld,
                          input logic [3:0] lv, input logic [3:0] sv, input logic h);
        if (s != 0) begin
            start1 = st; dir1 = d; load1 = ld; lv1 = lv; sv1 = sv; halt1 = h;
        end else begin
            start4 = st; dir4 = d; load4 = ld; lv4 = lv; sv4 = sv; halt4 = h;
        end
    endtask

    task automatic do_load(input int s, input int v);
        @(negedge clk);
        set_in(s, 1'b0, 1'b0, 1'b1, 4'(v), 4'd0, 1'b0);
        @(negedge clk);
        set_in(s, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        chk("load_code", code_of(s), v);
        chk("load_idle", act_of(s), 0);
        cur[s] = v;
    endtask

    task automatic do_run(input int s, input int td, input int d, input int stp,
                          input int steps, input int fin);
        int act = 0;
        int dones = 0;
        int prev;
        int c;
        q.delete();
        for (int i = 1; i <= steps; i++) q.push_back((d != 0 ? cur[s] - i : cur[s] + i) & 15);
        @(negedge clk);
        set_in(s, 1'b1, 1'(d), 1'b0, 4'd0, 4'(stp), 1'b0);
        prev = cur[s];
        c = prev;
        for (int cyc = 1; cyc <= 16 * td + 8; cyc++) begin
            @(negedge clk);
            if (cyc == 1) set_in(s, 1'b0, 1'(d), 1'b0, 4'd0, 4'(stp), 1'b0);
            c = code_of(s);
            if (act_of(s) != 0) act++;
            if (c != prev) begin
                if (q.size() == 0) chk("extra_step", c, -1);
                else chk("step_code", c, q.pop_front());
                chk("step_time", (cyc - 1) % td, 0);
                prev = c;
            end
            if (done_of(s) != 0) begin
                dones++;
                chk("done_at_last_step", q.size(), 0);
            end
            if (dones > 0 && done_of(s) == 0) break;
        end
        chk("queue_empty", q.size(), 0);
        chk("active_cycles", act, steps * td);
        chk("done_pulses", dones, 1);
        chk("final_code", c, fin);
        chk("idle_after", act_of(s), 0);
        cur[s] = fin;
    endtask

    initial begin
        int hd;
        rst = 1'b1;
        set_in(0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        set_in(1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        cur[0] = 0;
        cur[1] = 0;
        tbl[0] = '{lv: 3,  dir: 0, stop: 6,  steps: 3,  fin: 6};
        tbl[1] = '{lv: 14, dir: 0, stop: 1,  steps: 3,  fin: 1};
        tbl[2] = '{lv: 1,  dir: 1, stop: 14, steps: 3,  fin: 14};
        tbl[3] = '{lv: 5,  dir: 0, stop: 5,  steps: 16, fin: 5};
        tbl[4] = '{lv: 0,  dir: 1, stop: 0,  steps: 16, fin: 0};
        tbl[5] = '{lv: 9,  dir: 1, stop: 2,  steps: 7,  fin: 2};
        repeat (2) @(negedge clk);
        chk("rst_code", code_of(0), 0);
        chk("rst_active", act_of(0), 0);
        chk("rst_done", done_of(0), 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_load(0, tbl[i].lv);
            do_run(0, 4, tbl[i].dir, tbl[i].stop, tbl[i].steps, tbl[i].fin);
        end

        // Halt exactly on the second tick: code stays at the first step value.
        do_load(0, 2);
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd10, 1'b0);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 1) set_in(0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd10, 1'b0);
            if (cyc == 5) chk("halt_first_step", code_of(0), 3);
        end
        halt4 = 1'b1;
        @(negedge clk);
        halt4 = 1'b0;
        chk("halt_code", code_of(0), 3);
        chk("halt_active", act_of(0), 0);
        chk("halt_done", done_of(0), 0);
        hd = 0;
        repeat (6) begin
            @(negedge clk);
            hd += done_of(0) + act_of(0);
        end
        chk("halt_quiet", hd, 0);
        chk("halt_hold", code_of(0), 3);

        // Load and start together: load wins, no run.
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 1'b1, 4'd12, 4'd0, 1'b0);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        chk("ldst_code", code_of(0), 12);
        chk("ldst_active", act_of(0), 0);
        @(negedge clk);
        chk("ldst_still_idle", act_of(0), 0);
        cur[0] = 12;

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        repeat (5) @(negedge clk);
        chk("pre_rst_code", code_of(0), 13);
        chk("pre_rst_active", act_of(0), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_code", code_of(0), 0);
        chk("async_rst_active", act_of(0), 0);
        chk("async_rst_done", done_of(0), 0);
        @(negedge clk);
        chk("rst_no_done", done_of(0), 0);
        rst = 1'b0;
        cur[0] = 0;
        cur[1] = 0;
        do_run(0, 4, 0, 3, 3, 3);

        // Single-cycle tick divider.
        do_run(1, 1, 0, 3, 3, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
